// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory arbiter:
// FSM state encoding, requester port indices and interface width defaults.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. On a tie the port not granted last wins; the
// last-grant pointer moves only when the caller commits a grant.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output port_t      pick_o
);

    port_t last_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pick_o = PORT0;
        if (req_i == 2'b11) begin
            pick_o = (last_q == PORT0) ? PORT1 : PORT0;
        end else if (req_i[1]) begin
            pick_o = PORT1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= PORT1;
        end else if (update_i) begin
            last_q <= pick_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data caches onto one line-wide memory port.
// One transaction at a time: IDLE grants and latches, BUSY waits for memory, DONE acks.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [LINE_W-1:0] p0_data_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [LINE_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    state_t            state_q, state_d;
    port_t             pick;
    port_t             grant_q;
    logic              take;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic [LINE_W-1:0] rd_buf_q;

    rr_arbiter2 u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    ({p1_enable_i, p0_enable_i}),
        .update_i (take),
        .pick_o   (pick)
    );

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (p0_enable_i || p1_enable_i) begin
                    take    = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the line registers and read buffer are reset because outputs must read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            grant_q  <= PORT0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_buf_q <= '0;
        end else begin
            if (take) begin
                grant_q <= pick;
                wr_q    <= (pick == PORT1) ? p1_write_i : p0_write_i;
                addr_q  <= (pick == PORT1) ? p1_addr_i  : p0_addr_i;
                data_q  <= (pick == PORT1) ? p1_data_i  : p0_data_i;
            end
            if (state_q == ST_BUSY && mem_ack_i) begin
                rd_buf_q <= mem_data_i;
            end
        end
    end

    // Memory side sees only the latched copy, so requesters may change inputs mid-transaction.
    assign mem_enable_o = (state_q == ST_BUSY);
    assign mem_write_o  = wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;

    assign p0_ack_o  = (state_q == ST_DONE) && (grant_q == PORT0);
    assign p1_ack_o  = (state_q == ST_DONE) && (grant_q == PORT1);
    assign p0_data_o = rd_buf_q;
    assign p1_data_o = rd_buf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
    logic [ADDR_W-1:0] p0_addr_i = '0;
    logic [LINE_W-1:0] p0_data_i = '0;
    logic              p0_ack_o;
    logic [LINE_W-1:0] p0_data_o;
    logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
    logic [ADDR_W-1:0] p1_addr_i = '0;
    logic [LINE_W-1:0] p1_data_i = '0;
    logic              p1_ack_o;
    logic [LINE_W-1:0] p1_data_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i = 1'b0;
    logic [LINE_W-1:0] mem_data_i = '0;

    int cmp_count = 0;
    int err_count = 0;
    int cyc = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: at most one outstanding transaction; a completed one owes its
    // requester exactly one ack cycle, during which new requests are ignored.
    bit              m_busy = 0;
    bit              m_ack_due = 0;
    int              m_port = 0;
    int              m_last = 1;
    bit              m_write = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [LINE_W-1:0] m_data = '0;
    logic [LINE_W-1:0] m_rdbuf = '0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy = 0; m_ack_due = 0; m_port = 0; m_last = 1;
            m_write = 0; m_addr = '0; m_data = '0; m_rdbuf = '0;
        end else if (m_ack_due) begin
            m_ack_due = 0;
        end else if (m_busy) begin
            if (mem_ack_i) begin
                m_rdbuf   = mem_data_i;
                m_busy    = 0;
                m_ack_due = 1;
            end
        end else if (p0_enable_i || p1_enable_i) begin
            if (p0_enable_i && p1_enable_i) m_port = 1 - m_last;
            else                            m_port = p0_enable_i ? 0 : 1;
            m_last  = m_port;
            m_write = (m_port == 0) ? p0_write_i : p1_write_i;
            m_addr  = (m_port == 0) ? p0_addr_i  : p1_addr_i;
            m_data  = (m_port == 0) ? p0_data_i  : p1_data_i;
            m_busy  = 1;
        end
    end

    always @(negedge clk_i) begin
        check("mem_enable", LINE_W'(mem_enable_o), LINE_W'(m_busy));
        if (m_busy) begin
            check("mem_write", LINE_W'(mem_write_o), LINE_W'(m_write));
            check("mem_addr",  LINE_W'(mem_addr_o),  LINE_W'(m_addr));
            check("mem_data",  mem_data_o, m_data);
        end
        check("p0_ack", LINE_W'(p0_ack_o), LINE_W'(m_ack_due && m_port == 0));
        check("p1_ack", LINE_W'(p1_ack_o), LINE_W'(m_ack_due && m_port == 1));
        check("p0_data", p0_data_o, m_rdbuf);
        check("p1_data", p1_data_o, m_rdbuf);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_busy(input int budget);
        for (int i = 0; i < budget && !mem_enable_o; i++) step();
        check("busy_within_budget", LINE_W'(mem_enable_o), LINE_W'(1));
    endtask

    task automatic mem_pulse(input logic [LINE_W-1:0] d);
        mem_ack_i  = 1'b1;
        mem_data_i = d;
        step();
        mem_ack_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] line_a5;
        logic [LINE_W-1:0] line_w;
        int                last_ack;

        line_a5 = {32{8'hA5}};
        line_w  = {8{32'h1234_5678}};

        #1 rst_i = 1'b0;
        #1;
        check("rst_mem_enable", LINE_W'(mem_enable_o), '0);
        check("rst_mem_addr",   LINE_W'(mem_addr_o),   '0);
        check("rst_p0_data",    p0_data_o, '0);
        step(); step();
        rst_i = 1'b1;

        // Single read on p1, memory answers after 10 BUSY cycles.
        p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0400;
        wait_busy(5);
        check("r1_addr", LINE_W'(mem_addr_o), LINE_W'(32'h0000_0400));
        for (int i = 0; i < 10; i++) step();
        mem_pulse(line_a5);
        check("r1_p1_ack",  LINE_W'(p1_ack_o), LINE_W'(1));
        check("r1_p0_ack",  LINE_W'(p0_ack_o), '0);
        check("r1_p1_data", p1_data_o, line_a5);
        step();
        p1_enable_i = 1'b0;
        check("r1_ack_one_cycle", LINE_W'(p1_ack_o), '0);
        step(); step();

        // Reset, then simultaneous requests: p0, p1, then p0 re-requests and loses to p1.
        rst_i = 1'b0; step(); rst_i = 1'b1;
        p0_enable_i = 1'b1; p0_addr_i = 32'h0000_0100;
        p1_enable_i = 1'b1; p1_addr_i = 32'h0000_0200;
        wait_busy(5);
        check("rr_first_p0", LINE_W'(mem_addr_o), LINE_W'(32'h0000_0100));
        mem_pulse({LINE_W{1'b0}} | 256'h11);
        check("rr_p0_ack", LINE_W'(p0_ack_o), LINE_W'(1));
        p0_addr_i = 32'h0000_0180;
        wait_busy(5);
        check("rr_second_p1", LINE_W'(mem_addr_o), LINE_W'(32'h0000_0200));
        mem_pulse({LINE_W{1'b0}} | 256'h22);
        check("rr_p1_ack", LINE_W'(p1_ack_o), LINE_W'(1));
        step();
        p1_enable_i = 1'b0;
        wait_busy(5);
        check("rr_third_p0", LINE_W'(mem_addr_o), LINE_W'(32'h0000_0180));
        mem_pulse({LINE_W{1'b0}} | 256'h33);
        check("rr_p0_ack2", LINE_W'(p0_ack_o), LINE_W'(1));
        step();
        p0_enable_i = 1'b0;
        step();

        // Write on p1 with requester inputs changing mid-BUSY.
        p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h0000_0040; p1_data_i = line_w;
        wait_busy(5);
        p1_addr_i = 32'hFFFF_FFC0; p1_data_i = '1; p1_write_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wr_addr_stable",  LINE_W'(mem_addr_o),  LINE_W'(32'h0000_0040));
            check("wr_write_stable", LINE_W'(mem_write_o), LINE_W'(1));
            check("wr_data_stable",  mem_data_o, line_w);
            step();
        end
        mem_pulse({LINE_W{1'b0}} | 256'h44);
        check("wr_p1_ack", LINE_W'(p1_ack_o), LINE_W'(1));
        step();
        p1_enable_i = 1'b0; p1_write_i = 1'b0;
        step();

        // Reset three cycles into BUSY; memory acks two cycles after release.
        p0_enable_i = 1'b1; p0_addr_i = 32'h0000_0300;
        wait_busy(5);
        step(); step(); step();
        rst_i = 1'b0; p0_enable_i = 1'b0;
        #1;
        check("rst_async_enable", LINE_W'(mem_enable_o), '0);
        step();
        rst_i = 1'b1;
        step(); step();
        mem_pulse({32{8'h77}});
        check("late_ack_p0",  LINE_W'(p0_ack_o), '0);
        check("late_ack_p1",  LINE_W'(p1_ack_o), '0);
        check("late_ack_idle", LINE_W'(mem_enable_o), '0);
        step();
        check("late_ack_p0_next", LINE_W'(p0_ack_o), '0);

        // Spurious memory ack while idle: buffer keeps its reset value.
        mem_pulse({32{8'hDE}});
        check("spur_p0_ack", LINE_W'(p0_ack_o), '0);
        check("spur_enable", LINE_W'(mem_enable_o), '0);
        check("spur_p0_data", p0_data_o, '0);
        step();

        // Back-to-back p0 reads with zero-wait memory: acks exactly 3 cycles apart.
        p0_enable_i = 1'b1; p0_addr_i = 32'h0000_0500;
        last_ack = -1;
        for (int n = 0; n < 5; n++) begin
            wait_busy(6);
            mem_pulse({LINE_W{1'b0}} | LINE_W'(n + 256'h100));
            check("b2b_ack", LINE_W'(p0_ack_o), LINE_W'(1));
            if (last_ack >= 0) check("b2b_interval", LINE_W'(cyc - last_ack), LINE_W'(3));
            last_ack = cyc;
            step();
            check("b2b_no_consecutive", LINE_W'(p0_ack_o), '0);
        end
        p0_enable_i = 1'b0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory byte-address width.
REQ-002 Parameter LINE_W, default 256, cache-line data width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 p0_enable_i  in  1  port 0 (instruction cache) request, held until p0_ack_o.
REQ-006 p0_write_i  in  1  port 0 write (1) / read (0).
REQ-007 p0_addr_i  in  ADDR_W  port 0 line address.
REQ-008 p0_data_i  in  LINE_W  port 0 write line.
REQ-009 p0_ack_o  out  1  port 0 one-cycle completion pulse.
REQ-010 p0_data_o  out  LINE_W  port 0 read line, valid while p0_ack_o=1.
REQ-011 p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: same as REQ-005..010 for port 1 (data cache).
REQ-012 mem_enable_o  out  1  memory request, held until mem_ack_i.
REQ-013 mem_write_o  out  1  memory write (1) / read (0).
REQ-014 mem_addr_o  out  ADDR_W  memory line address.
REQ-015 mem_data_o  out  LINE_W  memory write line.
REQ-016 mem_ack_i  in  1  memory one-cycle completion pulse.
REQ-017 mem_data_i  in  LINE_W  memory read line, valid with mem_ack_i.

Function
REQ-018 FSM states SHALL be IDLE, BUSY, DONE.
REQ-019 IDLE: if any pN_enable_i=1, grant one port, latch its write/addr/data into internal registers, go to BUSY next cycle.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, the port not granted last wins; single requester wins immediately.
REQ-021 Last-grant pointer SHALL update only on grant.
REQ-022 BUSY: mem_enable_o=1; mem_write_o/mem_addr_o/mem_data_o driven from latched registers only, stable for whole BUSY, independent of later requester input changes.
REQ-023 BUSY with mem_ack_i=1: capture mem_data_i into read buffer, go to DONE; mem_enable_o=0 from next cycle.
REQ-024 DONE: assert ack of granted port for exactly one cycle; pN_data_o = read buffer (write transactions return buffer contents, don't-care); other port ack=0; go to IDLE.
REQ-025 Requester SHALL drop enable the cycle after its ack; arbiter ignores all enables during DONE, so earliest re-grant is the IDLE cycle after DONE.
REQ-026 Minimum transaction latency: enable seen in IDLE cycle t, mem_enable_o=1 at t+1, ack at t+1 gives pN_ack_o at t+2.
REQ-027 mem_ack_i in IDLE or DONE SHALL be ignored (no state change, no ack).
REQ-028 No timeout; BUSY held indefinitely until mem_ack_i.
REQ-029 pN_data_o SHALL hold read-buffer value when ack=0 (no X-propagation requirement beyond reset).

Reset
REQ-030 rst_i=0 SHALL immediately force state IDLE, all outputs 0, latched registers and read buffer 0, last-grant pointer = port 1 (so first tie goes to port 0).
REQ-031 Reset mid-BUSY abandons transaction; no ack issued; late mem_ack_i after release handled per REQ-027.
REQ-032 Release of rst_i synchronous to clk_i rising edge behaviour: first grant possible on first edge with rst_i=1.

Structure
REQ-033 FSM state encoding and port-index constants SHALL reside in the shared CPU package; ADDR_W/LINE_W defaults match dcache_top memory interface.
REQ-034 One sub-module, rr_arbiter2 (2-way round-robin pick plus pointer), is natural; remainder flat.
REQ-035 Block SHALL sit between dcache_top/instruction cache and the CPU top-level memory ports.

Verification
REQ-036 Single read p1, addr 0x0000_0400, mem acks after 10 cycles with line 0xA5..A5 -> p1_ack_o one cycle, p1_data_o=0xA5..A5, p0_ack_o=0.
REQ-037 p0 and p1 request same cycle after reset -> p0 granted first, p1 second; then both again -> p1 first (round-robin).
REQ-038 p1 write addr 0x0000_0040 data 0x1234..; requester changes p1_addr_i to 0xFFFF_FFC0 during BUSY -> mem_addr_o stays 0x0000_0040, mem_write_o=1 throughout.
REQ-039 rst_i pulled low 3 cycles into BUSY, mem_ack_i arrives 2 cycles after release -> no pN_ack_o, state IDLE, mem_enable_o=0.
REQ-040 Spurious mem_ack_i in IDLE with no requests -> no ack, no grant, outputs unchanged.
REQ-041 Back-to-back p0 requests with zero-wait ack -> ack every 3 cycles, never two acks in consecutive cycles.
